// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter and burst sequencer for the shared L2 port (ICache read, DCache read/write).
// Holds one pending request per requester, counts the burst words and pulses an ICache invalidate after DC writes.
module l2_port_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        ic_rreq,
  input  logic [31:0] ic_addr,
  input  logic [4:0]  ic_burst_size,
  output logic [31:0] ic_rdata,
  output logic        ic_busy,
  input  logic        dc_rreq,
  input  logic        dc_wreq,
  input  logic [31:0] dc_addr,
  input  logic [4:0]  dc_burst_size,
  input  logic [31:0] dc_wdata,
  output logic [31:0] dc_rdata,
  output logic        dc_busy,
  output logic        l2_rreq,
  output logic        l2_wreq,
  output logic [31:0] l2_addr,
  output logic [4:0]  l2_burst_size,
  output logic [31:0] l2_wdata,
  input  logic [31:0] l2_rdata,
  input  logic        l2_busy,
  output logic [26:0] invalid_line,
  output logic        invalid_req
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_XFER} state_t;

  state_t      state;
  logic        ic_v, dc_v, dc_w;
  logic [31:0] ic_a, dc_a;
  logic [4:0]  ic_b, dc_b;
  logic        own_dc;   // owner of the current/last grant; doubles as round-robin history
  logic        cur_wr;
  logic [4:0]  cnt;

  logic        active, ic_owned, dc_owned, ic_cap, dc_cap, pick_dc, done;
  logic [4:0]  last_word;

  always_comb begin
    active    = (state != S_IDLE);
    ic_owned  = active && !own_dc;
    dc_owned  = active && own_dc;
    ic_cap    = ic_rreq && !ic_v && !ic_owned;
    dc_cap    = (dc_rreq || dc_wreq) && !dc_v && !dc_owned;
    pick_dc   = dc_v && (!ic_v || !own_dc);
    // burst size 0 behaves as a single-word burst
    last_word = (l2_burst_size == 5'd0) ? 5'd0 : l2_burst_size - 5'd1;
    done      = (state == S_WAIT && !l2_busy && last_word == 5'd0) ||
                (state == S_XFER && cnt == last_word);
  end

  assign ic_rdata = l2_rdata;
  assign dc_rdata = l2_rdata;
  assign l2_wdata = (dc_owned && cur_wr) ? dc_wdata : 32'd0;
  assign ic_busy  = ic_owned ? (state == S_ISSUE || l2_busy) : (ic_rreq | ic_v);
  assign dc_busy  = dc_owned ? (state == S_ISSUE || l2_busy) : (dc_rreq | dc_wreq | dc_v);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      ic_v          <= 1'b0;
      ic_a          <= 32'd0;
      ic_b          <= 5'd0;
      dc_v          <= 1'b0;
      dc_w          <= 1'b0;
      dc_a          <= 32'd0;
      dc_b          <= 5'd0;
      own_dc        <= 1'b1;
      cur_wr        <= 1'b0;
      cnt           <= 5'd0;
      l2_rreq       <= 1'b0;
      l2_wreq       <= 1'b0;
      l2_addr       <= 32'd0;
      l2_burst_size <= 5'd0;
      invalid_line  <= 27'd0;
      invalid_req   <= 1'b0;
    end else begin
      l2_rreq     <= 1'b0;
      l2_wreq     <= 1'b0;
      invalid_req <= 1'b0;

      // a slot is only granted while valid and only captured while empty
      if (ic_cap) begin
        ic_v <= 1'b1;
        ic_a <= ic_addr;
        ic_b <= ic_burst_size;
      end else if (state == S_IDLE && ic_v && !pick_dc) begin
        ic_v <= 1'b0;
      end

      if (dc_cap) begin
        dc_v <= 1'b1;
        dc_w <= dc_wreq;
        dc_a <= dc_addr;
        dc_b <= dc_burst_size;
      end else if (state == S_IDLE && pick_dc) begin
        dc_v <= 1'b0;
      end

      case (state)
        S_IDLE: if (ic_v || dc_v) begin
          own_dc        <= pick_dc;
          cur_wr        <= pick_dc && dc_w;
          l2_addr       <= pick_dc ? dc_a : ic_a;
          l2_burst_size <= pick_dc ? dc_b : ic_b;
          l2_wreq       <= pick_dc && dc_w;
          l2_rreq       <= !(pick_dc && dc_w);
          state         <= S_ISSUE;
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: if (!l2_busy) begin
          if (last_word == 5'd0) state <= S_IDLE;
          else begin
            cnt   <= 5'd1;
            state <= S_XFER;
          end
        end
        S_XFER: if (cnt == last_word) state <= S_IDLE;
                else cnt <= cnt + 5'd1;
        default: state <= S_IDLE;
      endcase

      if (done && own_dc && cur_wr) begin
        invalid_req  <= 1'b1;
        invalid_line <= l2_addr[31:5];
      end
    end
  end
endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: directed scenarios plus random request mixes checked against
// a transaction-level model (pending slots, round-robin rule, words = max(1, burst)).
module tb_l2_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        ic_rreq, ic_busy, dc_rreq, dc_wreq, dc_busy;
  logic [31:0] ic_addr, ic_rdata, dc_addr, dc_wdata, dc_rdata;
  logic [4:0]  ic_burst_size, dc_burst_size, l2_burst_size;
  logic        l2_rreq, l2_wreq, l2_busy, invalid_req;
  logic [31:0] l2_addr, l2_wdata, l2_rdata;
  logic [26:0] invalid_line;

  l2_port_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_rreq(ic_rreq), .ic_addr(ic_addr), .ic_burst_size(ic_burst_size),
    .ic_rdata(ic_rdata), .ic_busy(ic_busy),
    .dc_rreq(dc_rreq), .dc_wreq(dc_wreq), .dc_addr(dc_addr), .dc_burst_size(dc_burst_size),
    .dc_wdata(dc_wdata), .dc_rdata(dc_rdata), .dc_busy(dc_busy),
    .l2_rreq(l2_rreq), .l2_wreq(l2_wreq), .l2_addr(l2_addr), .l2_burst_size(l2_burst_size),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_busy(l2_busy),
    .invalid_line(invalid_line), .invalid_req(invalid_req)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: index 0 = IC, 1 = DC
  logic        m_v [2];
  logic [31:0] m_a [2];
  logic [4:0]  m_b [2];
  logic        m_w [2];
  int          m_last;
  int          m_owner;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 1'b0; m_a[i] = '0; m_b[i] = '0; m_w[i] = 1'b0;
    end
    m_last  = 1;
    m_owner = -1;
  endtask

  function automatic logic bz(input int o);
    return (o == 0) ? ic_busy : dc_busy;
  endfunction

  function automatic int pick();
    if (m_v[0] && m_v[1]) return (m_last == 1) ? 0 : 1;
    return m_v[0] ? 0 : 1;
  endfunction

  function automatic logic [31:0] rnd_addr();
    return $urandom & 32'hFFFF_FFE0;
  endfunction

  task automatic clr_req();
    ic_rreq = 1'b0; dc_rreq = 1'b0; dc_wreq = 1'b0;
  endtask

  task automatic post_req(input int who, input logic [31:0] a, input logic [4:0] b, input logic wr);
    if (who == 0) begin
      ic_rreq = 1'b1; ic_addr = a; ic_burst_size = b;
    end else begin
      dc_rreq = !wr; dc_wreq = wr; dc_addr = a; dc_burst_size = b;
    end
    if (!m_v[who] && m_owner != who) begin
      m_v[who] = 1'b1; m_a[who] = a; m_b[who] = b; m_w[who] = (who == 1) && wr;
    end
  endtask

  task automatic do_reset();
    clr_req();
    l2_busy = 1'b0;
    reset = 1'b0;
    model_reset();
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  // request cycle, then the grant-decision cycle
  task automatic kick(input bit do_ic, input bit do_dc, input logic [31:0] ia, input logic [31:0] da,
                      input logic [4:0] ib, input logic [4:0] db, input logic dw);
    if (do_ic) post_req(0, ia, ib, 1'b0);
    if (do_dc) post_req(1, da, db, dw);
    #1;
    if (do_ic) chk("ic_busy_comb", 32'(ic_busy), 32'd1);
    if (do_dc) chk("dc_busy_comb", 32'(dc_busy), 32'd1);
    tick();
    clr_req();
    chk("decide_no_pulse", 32'(l2_rreq | l2_wreq), 32'd0);
  endtask

  // entered in the ISSUE cycle, returns in the IDLE cycle after the last word
  task automatic serve(input bit inject);
    int o, n, d;
    logic [31:0] ea, rd;
    logic [4:0]  eb;
    logic        ew;
    clr_req();
    o  = pick();
    ea = m_a[o]; eb = m_b[o]; ew = m_w[o];
    m_v[o] = 1'b0; m_last = o; m_owner = o;
    n = (eb == 5'd0) ? 1 : int'(eb);
    chk("inv_clear", 32'(invalid_req), 32'd0);
    chk("l2_rreq", 32'(l2_rreq), 32'(!ew));
    chk("l2_wreq", 32'(l2_wreq), 32'(ew));
    chk("l2_addr", l2_addr, ea);
    chk("l2_bsize", 32'(l2_burst_size), 32'(eb));
    chk("own_busy_issue", 32'(bz(o)), 32'd1);
    tick();
    chk("pulse_once", 32'(l2_rreq | l2_wreq), 32'd0);
    l2_busy = 1'b1;
    d = $urandom_range(1, 3);
    for (int i = 0; i < d; i++) begin
      if (i == 0 && inject && !m_v[1-o])
        post_req(1 - o, rnd_addr(), 5'($urandom_range(0, 16)), (o == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
      #1;
      chk("own_busy_wait", 32'(bz(o)), 32'd1);
      chk("oth_busy_wait", 32'(bz(1 - o)), 32'(m_v[1-o]));
      tick();
      clr_req();
    end
    l2_busy = 1'b0;
    for (int k = 0; k < n; k++) begin
      dc_wdata = 32'(k);
      rd = $urandom;
      l2_rdata = rd;
      #1;
      chk("l2_wdata", l2_wdata, ew ? 32'(k) : 32'd0);
      chk("rdata", (o == 0) ? ic_rdata : dc_rdata, rd);
      chk("own_busy_data", 32'(bz(o)), 32'd0);
      chk("oth_busy_data", 32'(bz(1 - o)), 32'(m_v[1-o]));
      tick();
    end
    m_owner = -1;
    chk("inv_req", 32'(invalid_req), 32'(ew));
    if (ew) chk("inv_line", 32'(invalid_line), {5'd0, ea[31:5]});
    chk("idle_no_pulse", 32'(l2_rreq | l2_wreq), 32'd0);
  endtask

  task automatic drain(input bit inj);
    int it = 0;
    while (m_v[0] || m_v[1]) begin
      tick();
      serve(inj && it < 4 && $urandom_range(0, 1) == 1);
      it++;
    end
  endtask

  initial begin
    reset = 1'b0;
    ic_rreq = 0; ic_addr = 0; ic_burst_size = 0;
    dc_rreq = 0; dc_wreq = 0; dc_addr = 0; dc_burst_size = 0; dc_wdata = 0;
    l2_rdata = 0; l2_busy = 0;
    model_reset();
    #3;
    chk("rst_rreq", 32'(l2_rreq), 32'd0);
    chk("rst_wreq", 32'(l2_wreq), 32'd0);
    chk("rst_addr", l2_addr, 32'd0);
    chk("rst_bsize", 32'(l2_burst_size), 32'd0);
    chk("rst_inv_req", 32'(invalid_req), 32'd0);
    chk("rst_inv_line", 32'(invalid_line), 32'd0);
    chk("rst_busy", 32'({ic_busy, dc_busy}), 32'd0);
    do_reset();

    // IC read alone
    kick(1, 0, 32'h1000_0040, 32'd0, 5'd8, 5'd0, 1'b0);
    drain(1'b0);

    // simultaneous IC/DC reads after reset: IC first
    do_reset();
    kick(1, 1, 32'h1000_0080, 32'h3000_0100, 5'd8, 5'd8, 1'b0);
    drain(1'b0);

    // three consecutive simultaneous pairs
    for (int p = 0; p < 3; p++) begin
      kick(1, 1, rnd_addr(), rnd_addr(), 5'd4, 5'd4, 1'b0);
      drain(1'b0);
    end

    // DC write with invalidate
    kick(0, 1, 32'd0, 32'h2000_00A0, 5'd0, 5'd8, 1'b1);
    drain(1'b0);
    tick();
    chk("inv_one_cycle", 32'(invalid_req), 32'd0);

    // burst sizes 0 and 1
    kick(1, 0, rnd_addr(), 32'd0, 5'd0, 5'd0, 1'b0);
    drain(1'b0);
    kick(0, 1, 32'd0, rnd_addr(), 5'd0, 5'd1, 1'b1);
    drain(1'b0);

    // reset during XFER word 3
    kick(1, 0, 32'h1000_0040, 32'd0, 5'd8, 5'd0, 1'b0);
    tick();
    chk("mid_pulse", 32'(l2_rreq), 32'd1);
    tick(); l2_busy = 1'b1;
    tick(); l2_busy = 1'b0;
    tick(); tick(); tick();
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_addr", l2_addr, 32'd0);
    chk("mid_rst_bsize", 32'(l2_burst_size), 32'd0);
    chk("mid_rst_req", 32'({l2_rreq, l2_wreq, invalid_req}), 32'd0);
    chk("mid_rst_busy", 32'({ic_busy, dc_busy}), 32'd0);
    model_reset();
    tick();
    reset = 1'b1;
    tick(); tick();
    chk("post_rst_quiet", 32'({l2_rreq, l2_wreq, ic_busy, dc_busy}), 32'd0);
    kick(1, 0, 32'h1000_0040, 32'd0, 5'd8, 5'd0, 1'b0);
    drain(1'b0);

    // randomized mixes with mid-burst arrivals and dropped duplicates
    for (int r = 0; r < 30; r++) begin
      int mode;
      mode = $urandom_range(0, 2);
      kick(mode != 1, mode != 0, rnd_addr(), rnd_addr(),
           5'($urandom_range(0, 16)), 5'($urandom_range(0, 16)), 1'($urandom_range(0, 1)));
      if (m_v[0] && $urandom_range(0, 3) == 0) begin
        ic_rreq = 1'b1;
        ic_addr = rnd_addr();
        ic_burst_size = 5'($urandom_range(1, 16));
      end
      drain(1'b1);
      tick();
      chk("rand_idle", 32'({l2_rreq, l2_wreq, ic_busy, dc_busy, invalid_req}), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/l2_port_arbiter.md
# l2_port_arbiter

Two-requester arbiter and burst sequencer for the single L2 port shared by the L1 instruction and data caches. It latches one-cycle read or write requests from the ICache and DCache, grants the L2 port round-robin, and issues a registered request pulse downstream. It then counts the burst words, gates each cache's busy line, and on completion of a DCache write burst pulses an ICache line invalidation. It sits between the L1 caches and the L2/memory controller.

## Interface
Parameters:
- None. Widths are fixed: 32-bit addresses and data, 5-bit burst size, 27-bit line tag+set.

Ports (`reset` is asynchronous, active-low):
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- ic_rreq  in  1  ICache read request, one-cycle pulse
- ic_addr  in  32  ICache burst start address (line-aligned)
- ic_burst_size  in  5  ICache burst length in words
- ic_rdata  out  32  read data, equals l2_rdata
- ic_busy  out  1  ICache-side busy
- dc_rreq  in  1  DCache read request pulse
- dc_wreq  in  1  DCache write request pulse
- dc_addr  in  32  DCache burst start address
- dc_burst_size  in  5  DCache burst length in words
- dc_wdata  in  32  DCache write data, one word per transfer cycle
- dc_rdata  out  32  read data, equals l2_rdata
- dc_busy  out  1  DCache-side busy
- l2_rreq  out  1  downstream read request pulse (registered)
- l2_wreq  out  1  downstream write request pulse (registered)
- l2_addr  out  32  downstream address (registered, held until next grant)
- l2_burst_size  out  5  downstream burst length (registered)
- l2_wdata  out  32  dc_wdata when DC owns a write, else 0
- l2_rdata  in  32  downstream read data
- l2_busy  in  1  downstream busy
- invalid_line  out  27  {tag, set} for ICache invalidation
- invalid_req  out  1  one-cycle invalidate pulse

## Operation
- Pending registers: one slot per requester (valid, addr, burst, write flag). A slot is captured on a clock edge where its rreq/wreq is high and the slot is empty and not owned. Requests arriving while the requester's slot is pending or owned are protocol violations and are dropped. If dc_rreq and dc_wreq are both high, the write wins.
- Round-robin: if only one slot is valid, that slot is granted. If both are valid, the requester not granted last is granted. last_grant resets to DC, so the first tie goes to IC.
- Burst size 0 is treated as 1. Legal range is 1..16. The word counter is 5 bits and compares against burst−1.
- States:
  - IDLE: if any slot is valid, grant it, load l2_addr and l2_burst_size, and assert l2_rreq or l2_wreq. Clear the slot, record the owner, go to ISSUE.
  - ISSUE: drop the request pulse, go to WAIT.
  - WAIT: when l2_busy=0, word 0 transfers this cycle. If burst=1, go to IDLE; else set count=1 and go to XFER.
  - XFER: one word per cycle. When count=burst−1, go to IDLE; else count+1.
- Busy:
  - Owner busy = 1 in ISSUE and = l2_busy in WAIT/XFER.
  - Non-owner busy = its rreq/wreq input | slot valid.
  - In IDLE, busy = input request | slot valid. This is combinational, so busy is high in the same cycle as the request pulse.
- Invalidate: on the IDLE transition ending a DC write burst, assert invalid_req=1 for one cycle with invalid_line=l2_addr[31:5].
- Reset values: l2_rreq, l2_wreq, and invalid_req are 0. l2_addr, l2_burst_size, and invalid_line are 0. State is IDLE, both slots are empty, last_grant=DC.
- Reset asserted mid-burst: the burst is abandoned immediately and all outputs take their reset values.

## Timing
- Request pulse in cycle C is captured at the end of C. The grant is decided in C+1, and l2_rreq/l2_wreq is high during C+2 only.
- The downstream L2 must raise l2_busy by C+3 (the first WAIT cycle).
- Data words stream on consecutive cycles starting with the first cycle in which l2_busy=0 in WAIT. Total words = burst.
- Back-to-back: the next grant can issue its request pulse 2 cycles after the last data word of the previous burst (IDLE decide, then ISSUE).
- A request pulse from the non-owner in any state is captured, and that requester's busy stays high until its own burst's data phase.

## Test plan
- IC read alone, ic_addr=0x1000_0040, burst 8 → l2_rreq pulse two cycles later with l2_addr=0x1000_0040 and l2_burst_size=8. ic_busy=1 until l2_busy falls, then 8 words pass, then IDLE.
- IC and DC read pulse in the same cycle after reset → IC granted first. DC's l2_rreq issues 2 cycles after IC's 8th word, and dc_busy stays 1 throughout IC's burst.
- Three consecutive simultaneous pairs → grants alternate IC, DC, IC, DC, IC, DC.
- DC write to 0x2000_00A0, burst 8, dc_wdata=k per word → l2_wreq pulse and l2_wdata=k on word k. invalid_req=1 for one cycle with invalid_line=0x100_0005. No invalidate occurs after reads.
- Burst size 0 and burst size 1 → exactly one data word, then return to IDLE.
- reset low during XFER word 3 → outputs immediately 0, slots cleared. A fresh IC request after release completes normally.
